x1_gram_arbiter: RTL

Shares the single-ported three-plane GRAM (Blue/Red/Green, 8 bits each, common address) between the Z80 bus and the CRTC video fetch. Video fetches have priority, bounded by a starvation guard so CPU accesses always complete. The block drives Z80 wait for CPU accesses and returns all three planes in one access for each video fetch. It sits between the address decoder's GRAM chip-selects, the GRAM instances and the video shifter.

---
 rtl/x1_pkg.sv | 36 +++
 rtl/x1_gram_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/x1_pkg.sv
`timescale 1ns/1ps
// x1_pkg
//    Shared definitions for the X1 GRAM arbiter slice: plane encodings,
//    arbiter FSM state type/encodings, default GRAM address width and a
//    small helper mapping a CPU plane select onto per-plane write enables.
package x1_pkg;

   localparam int GRAM_AW = 14;

   localparam logic [1:0] PLANE_B    = 2'd0;
   localparam logic [1:0] PLANE_R    = 2'd1;
   localparam logic [1:0] PLANE_G    = 2'd2;
   localparam logic [1:0] PLANE_NONE = 2'd3;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t ST_IDLE  = 2'd0;
   localparam arb_state_t ST_ISSUE = 2'd1;
   localparam arb_state_t ST_LAT   = 2'd2;
   localparam arb_state_t ST_DONE  = 2'd3;

   // Write enables ordered {G,R,B}; the "no plane" select writes nothing.
   function automatic logic [2:0] plane_we(input logic [1:0] plane);
      logic [2:0] we;
      we = 3'b000;
      case (plane)
         PLANE_B:    we = 3'b001;
         PLANE_R:    we = 3'b010;
         PLANE_G:    we = 3'b100;
         PLANE_NONE: we = 3'b000;
         default:    we = 3'b000;
      endcase
      return we;
   endfunction

endpackage

// File: rtl/x1_gram_arbiter.sv
`timescale 1ns/1ps
// x1_gram_arbiter
//    Shares the single-ported three-plane GRAM (B/R/G, common address)
//    between Z80 accesses and CRTC video fetches. Video has priority,
//    limited by a streak counter so a waiting CPU access always completes.
//
//    Ports:
//       clk_sys, reset        system clock, async active-high reset
//       cpu_req/we/plane      CPU request (level until ack), direction, plane
//       cpu_addr/din          CPU address and write data
//       cpu_dout/ack          CPU read data (held) and one-cycle completion
//       cpu_wait_n            Z80 WAIT_n, low while a CPU access is pending
//       vid_req/vid_addr      one-cycle fetch request and its address
//       vid_data/vid_valid    fetched {G,R,B} (held) and one-cycle strobe
//       vid_overrun           sticky: fetch request replaced a pending one
//       mem_addr/we/din       GRAM address, per-plane write enables, data
//       mem_q                 GRAM read data {G,R,B}, RD_LAT after address
module x1_gram_arbiter
   import x1_pkg::*;
#(
   parameter int AW             = GRAM_AW,
   parameter int RD_LAT         = 1,
   parameter int MAX_VID_STREAK = 4
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [1:0]    cpu_plane,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_din,
   output logic [7:0]    cpu_dout,
   output logic          cpu_ack,
   output logic          cpu_wait_n,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic [23:0]   vid_data,
   output logic          vid_valid,
   output logic          vid_overrun,
   output logic [AW-1:0] mem_addr,
   output logic [2:0]    mem_we,
   output logic [7:0]    mem_din,
   input  logic [23:0]   mem_q
);

   localparam int SW = $clog2(MAX_VID_STREAK + 1);
   localparam int LW = $clog2(RD_LAT + 1);

   arb_state_t    r_state;
   logic          r_vp;
   logic [AW-1:0] r_vaddr;
   logic          r_cpu_done;
   logic [SW-1:0] r_streak;
   logic          r_gnt_vid;
   logic          r_we;
   logic [1:0]    r_plane;
   logic [LW-1:0] r_lat;
   logic [7:0]    r_cpu_dout;
   logic          r_cpu_ack;
   logic [23:0]   r_vid_data;
   logic          r_vid_valid;
   logic          r_overrun;
   logic [AW-1:0] r_mem_addr;
   logic [2:0]    r_mem_we;
   logic [7:0]    r_mem_din;

   logic          w_cp;
   logic          w_idle;
   logic          w_vp_any;
   logic          w_streak_ok;
   logic          w_gnt_vid;
   logic          w_gnt_cpu;
   logic [AW-1:0] w_gnt_vaddr;
   logic          w_lat_last;
   logic [7:0]    w_cpu_byte;

   assign w_cp        = cpu_req & ~r_cpu_done;
   assign w_idle      = (r_state == ST_IDLE);
   // A request arriving in an idle cycle is considered pending right away,
   // so a simultaneous CPU request still loses to video.
   assign w_vp_any    = r_vp | vid_req;
   assign w_streak_ok = (r_streak < SW'(MAX_VID_STREAK));
   assign w_gnt_vid   = w_idle & w_vp_any & (~w_cp | w_streak_ok);
   assign w_gnt_cpu   = w_idle & ~w_gnt_vid & w_cp;
   // An already latched request is older than one arriving this cycle.
   assign w_gnt_vaddr = r_vp ? r_vaddr : vid_addr;
   assign w_lat_last  = (r_lat == LW'(RD_LAT));

   always_comb begin
      w_cpu_byte = 8'hFF;
      case (r_plane)
         PLANE_B: w_cpu_byte = mem_q[7:0];
         PLANE_R: w_cpu_byte = mem_q[15:8];
         PLANE_G: w_cpu_byte = mem_q[23:16];
         default: w_cpu_byte = 8'hFF;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_vp        <= 1'b0;
         r_vaddr     <= '0;
         r_cpu_done  <= 1'b0;
         r_streak    <= '0;
         r_gnt_vid   <= 1'b0;
         r_we        <= 1'b0;
         r_plane     <= PLANE_NONE;
         r_lat       <= '0;
         r_cpu_dout  <= 8'hFF;
         r_cpu_ack   <= 1'b0;
         r_vid_data  <= '0;
         r_vid_valid <= 1'b0;
         r_overrun   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_we    <= '0;
         r_mem_din   <= '0;
      end else begin
         r_cpu_ack   <= 1'b0;
         r_vid_valid <= 1'b0;
         r_mem_we    <= '0;

         // Completion latch keeps a still-held request from running twice.
         if (!cpu_req)
            r_cpu_done <= 1'b0;
         else if (r_cpu_ack)
            r_cpu_done <= 1'b1;

         // Video pending flag and address latch.
         if (w_gnt_vid) begin
            if (r_vp && vid_req)
               r_vaddr <= vid_addr;
            else
               r_vp <= 1'b0;
         end else if (vid_req) begin
            r_vp    <= 1'b1;
            r_vaddr <= vid_addr;
            if (r_vp)
               r_overrun <= 1'b1;
         end

         if (w_idle) begin
            if (!w_cp)
               r_streak <= '0;
            else if (w_gnt_vid) begin
               if (w_streak_ok)
                  r_streak <= r_streak + 1'b1;
            end else
               r_streak <= '0;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_gnt_vid) begin
                  r_gnt_vid  <= 1'b1;
                  r_we       <= 1'b0;
                  r_plane    <= PLANE_NONE;
                  r_mem_addr <= w_gnt_vaddr;
                  r_state    <= ST_ISSUE;
               end else if (w_gnt_cpu) begin
                  r_gnt_vid  <= 1'b0;
                  r_we       <= cpu_we;
                  r_plane    <= cpu_plane;
                  r_mem_addr <= cpu_addr;
                  // Enables are registered here so they are high during ISSUE.
                  if (cpu_we) begin
                     r_mem_we  <= plane_we(cpu_plane);
                     r_mem_din <= cpu_din;
                  end
                  r_state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (!r_gnt_vid && r_we) begin
                  r_cpu_ack <= 1'b1;
                  r_state   <= ST_DONE;
               end else begin
                  r_lat   <= LW'(1);
                  r_state <= ST_LAT;
               end
            end
            ST_LAT: begin
               if (w_lat_last) begin
                  if (r_gnt_vid) begin
                     r_vid_data  <= mem_q;
                     r_vid_valid <= 1'b1;
                  end else begin
                     r_cpu_dout <= w_cpu_byte;
                     r_cpu_ack  <= 1'b1;
                  end
                  r_state <= ST_DONE;
               end else begin
                  r_lat <= r_lat + 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign cpu_dout    = r_cpu_dout;
   assign cpu_ack     = r_cpu_ack;
   assign cpu_wait_n  = ~w_cp;
   assign vid_data    = r_vid_data;
   assign vid_valid   = r_vid_valid;
   assign vid_overrun = r_overrun;
   assign mem_addr    = r_mem_addr;
   assign mem_we      = r_mem_we;
   assign mem_din     = r_mem_din;

endmodule
